rob_nport: RTL and testbench
============================

# rob_nport

Parametrised reorder buffer for the Tomasulo LC-3b core. It tracks in-flight instructions in program order and accepts results from NUM_CDB common data bus ports in the same cycle. It serves two operand lookups with same-cycle CDB bypass, and presents the oldest entry to write-results control for in-order retirement. It sits between issue control (allocation, operand lookup), the execution units and load/store buffer (CDB producers), and write-results control (retire, flush).

## Interface
- DEPTH, 8, entry count; power of two, at least 2; ADDR = $clog2(DEPTH)
- WIDTH, 16, data value width
- NUM_CDB, 2, number of CDB write ports, at least 1
- OP_BITS, 4, opcode width
- REG_BITS, 3, architectural register index width

Ports (direction, width, meaning):
- clk  in  1  clock; single clock domain, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries (mispredict)
- we  in  1  allocate one entry at tail
- opcode_in  in  OP_BITS  opcode of allocated instruction
- dest_in  in  REG_BITS  destination register
- value_in  in  WIDTH  initial value (used when ready_in=1)
- ready_in  in  1  entry is born complete (e.g. immediate results)
- predict_in  in  1  branch prediction bit
- alloc_addr  out  ADDR  tag given to the allocation this cycle (= tail)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDR+1  occupied entries
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*ADDR  per-port tag, port i at [i*ADDR +: ADDR]
- cdb_value  in  NUM_CDB*WIDTH  per-port value
- sr1_tag, sr2_tag  in  ADDR  lookup tags
- sr1_value, sr2_value  out  WIDTH  lookup values
- sr1_valid, sr2_valid  out  1  lookup value is available
- head_valid  out  1  head occupied and ready
- head_addr  out  ADDR  head tag
- head_opcode  out  OP_BITS; head_dest  out  REG_BITS; head_value  out  WIDTH; head_predict  out  1  head entry fields
- re  in  1  retire head

## Operation
- Circular buffer with head and tail pointers, each ADDR bits, wrapping modulo DEPTH. Per-entry fields: busy, ready, opcode, dest, value, predict.
- Allocate when we && !full: write the fields at tail, set busy=1, set ready=ready_in, tail+1. If we is asserted while full, the request is ignored and no state changes. A retire in the same cycle does not free a slot for that cycle's allocation.
- Retire when re && head_valid: clear busy at head, head+1. If re is asserted while head_valid=0, it is ignored.
- Count update: +1 on allocate, -1 on retire, unchanged when both occur in the same cycle.
- CDB writes: for each port i with cdb_valid[i], if entry cdb_tag[i] is busy and not ready, write the value and set ready=1. Writes to non-busy or already-ready entries are dropped. If two ports target the same tag in one cycle, the lowest index wins. A CDB write to the tag being allocated in the same cycle is dropped, and the allocation fields win.
- Lookup (combinational):
  - If the entry is busy and ready, return the stored value with valid=1.
  - Otherwise, if a valid CDB port matches the tag and the entry is busy, return that port's value (lowest index wins) with valid=1.
  - Otherwise valid=0 and value = stored field.
- flush: clears all busy and ready bits and sets head=tail=count=0. It has priority over we, re and CDB in the same cycle.
- Reset: same effect as flush, applied asynchronously. Data fields are not cleared.

## Timing
- Reset values: full=0, empty=1, count=0, alloc_addr=0, head_valid=0, head_addr=0, sr*_valid=0.
- alloc_addr is valid in the allocation cycle. The new entry is visible to lookup and head from the next cycle.
- CDB to lookup: valid in the same cycle through the bypass. CDB to head_valid: next cycle.
- Minimum allocate-to-retire latency is 1 cycle, for a ready_in=1 entry allocated into an empty buffer.
- Throughput: 1 allocate, 1 retire and NUM_CDB result writes per cycle.
- Deasserting reset_n mid-operation discards all entries immediately. The first allocation after release receives tag 0.

## Test plan
- Reset, then 8 allocations (DEPTH=8) with no CDB -> alloc_addr 0..7, full=1 after the 8th, count=8. A 9th we is ignored and tail stays 0.
- Allocate tags 0,1. CDB port0 tag1=0x1234 and port1 tag0=0xBEEF in one cycle -> next cycle head_valid=1, head_value=0xBEEF. Retire twice -> second head_value=0x1234, then empty=1.
- Fill, retire 3, allocate 3 -> alloc_addr wraps to 0,1,2. Results must retire in order 3..7,0,1,2.
- Both CDB ports write tag 2 in the same cycle (0x0011 on port0, 0x0022 on port1) -> stored value 0x0011. A later CDB to tag 2 with 0x0033 is dropped.
- Entry 4 busy and not ready, sr1_tag=4, CDB port1 tag4=0x00AA in the same cycle -> sr1_valid=1, sr1_value=0x00AA in that cycle.
- Five entries live, flush together with we and re asserted -> next cycle count=0, empty=1, alloc_addr=0. Same stimulus with reset_n pulsed low mid-cycle gives the same result immediately.

Source files
------------

// File: rtl/rob_nport.sv
// rob_nport: circular reorder buffer with NUM_CDB result write ports, two
// operand lookups with same-cycle CDB bypass, and in-order head retirement.
module rob_nport #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_CDB  = 2,
    parameter int unsigned OP_BITS  = 4,
    parameter int unsigned REG_BITS = 3,
    localparam int unsigned ADDR    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     we,
    input  logic [OP_BITS-1:0]       opcode_in,
    input  logic [REG_BITS-1:0]      dest_in,
    input  logic [WIDTH-1:0]         value_in,
    input  logic                     ready_in,
    input  logic                     predict_in,
    output logic [ADDR-1:0]          alloc_addr,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR:0]            count,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ADDR-1:0]  cdb_tag,
    input  logic [NUM_CDB*WIDTH-1:0] cdb_value,
    input  logic [ADDR-1:0]          sr1_tag,
    input  logic [ADDR-1:0]          sr2_tag,
    output logic [WIDTH-1:0]         sr1_value,
    output logic [WIDTH-1:0]         sr2_value,
    output logic                     sr1_valid,
    output logic                     sr2_valid,
    output logic                     head_valid,
    output logic [ADDR-1:0]          head_addr,
    output logic [OP_BITS-1:0]       head_opcode,
    output logic [REG_BITS-1:0]      head_dest,
    output logic [WIDTH-1:0]         head_value,
    output logic                     head_predict,
    input  logic                     re
);

    logic [DEPTH-1:0]    r_busy;
    logic [DEPTH-1:0]    r_ready;
    logic [OP_BITS-1:0]  r_opcode  [DEPTH];
    logic [REG_BITS-1:0] r_dest    [DEPTH];
    logic [WIDTH-1:0]    r_value   [DEPTH];
    logic                r_predict [DEPTH];
    logic [ADDR-1:0]     r_head;
    logic [ADDR-1:0]     r_tail;
    logic [ADDR:0]       r_count;

    logic                w_alloc;
    logic                w_retire;
    logic [DEPTH-1:0]    w_cdb_hit;
    logic [WIDTH-1:0]    w_cdb_val [DEPTH];
    logic [DEPTH-1:0]    w_cdb_wr;

    assign full       = (r_count == (ADDR+1)'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign alloc_addr = r_tail;

    assign head_valid   = r_busy[r_head] & r_ready[r_head];
    assign head_addr    = r_head;
    assign head_opcode  = r_opcode[r_head];
    assign head_dest    = r_dest[r_head];
    assign head_value   = r_value[r_head];
    assign head_predict = r_predict[r_head];

    // A retire this cycle never frees a slot for this cycle's allocation.
    assign w_alloc  = we & ~full;
    assign w_retire = re & head_valid;

    // Per-entry CDB match; scanning high to low lets the lowest port win.
    always_comb begin
        w_cdb_hit = '0;
        w_cdb_wr  = '0;
        for (int e = 0; e < int'(DEPTH); e++) begin
            w_cdb_val[e] = '0;
            for (int p = int'(NUM_CDB) - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_tag[p*ADDR +: ADDR] == ADDR'(e))) begin
                    w_cdb_hit[e] = 1'b1;
                    w_cdb_val[e] = cdb_value[p*WIDTH +: WIDTH];
                end
            end
            // Writes to the slot being allocated lose to the allocation.
            w_cdb_wr[e] = w_cdb_hit[e] & r_busy[e] & ~r_ready[e] &
                          ~(w_alloc && (r_tail == ADDR'(e)));
        end
    end

    // Operand lookup: stored ready value first, else same-cycle CDB bypass.
    always_comb begin
        sr1_valid = 1'b0;
        sr1_value = r_value[sr1_tag];
        if (r_busy[sr1_tag] && r_ready[sr1_tag]) begin
            sr1_valid = 1'b1;
        end else if (r_busy[sr1_tag] && w_cdb_hit[sr1_tag]) begin
            sr1_valid = 1'b1;
            sr1_value = w_cdb_val[sr1_tag];
        end
        sr2_valid = 1'b0;
        sr2_value = r_value[sr2_tag];
        if (r_busy[sr2_tag] && r_ready[sr2_tag]) begin
            sr2_valid = 1'b1;
        end else if (r_busy[sr2_tag] && w_cdb_hit[sr2_tag]) begin
            sr2_valid = 1'b1;
            sr2_value = w_cdb_val[sr2_tag];
        end
    end

    // Control state: occupancy flags, pointers and count; flush squashes all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (w_cdb_wr[e]) begin
                    r_ready[e] <= 1'b1;
                end
            end
            if (w_retire) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + ADDR'(1);
            end
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= ready_in;
                r_tail          <= r_tail + ADDR'(1);
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + (ADDR+1)'(1);
                2'b01:   r_count <= r_count - (ADDR+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; never reset, only meaningful while the entry is busy.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (w_cdb_wr[e]) begin
                    r_value[e] <= w_cdb_val[e];
                end
            end
            if (w_alloc) begin
                r_opcode[r_tail]  <= opcode_in;
                r_dest[r_tail]    <= dest_in;
                r_value[r_tail]   <= value_in;
                r_predict[r_tail] <= predict_in;
            end
        end
    end

endmodule

// File: tb/tb_rob_nport.sv
// tb_rob_nport: directed stimulus against rob_nport with a queue-based model
// of the in-flight instruction list checked on every falling clock edge.
module tb_rob_nport;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        we;
    logic [3:0]  opcode_in;
    logic [2:0]  dest_in;
    logic [15:0] value_in;
    logic        ready_in;
    logic        predict_in;
    logic [2:0]  alloc_addr;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [2:0]  sr1_tag;
    logic [2:0]  sr2_tag;
    logic [15:0] sr1_value;
    logic [15:0] sr2_value;
    logic        sr1_valid;
    logic        sr2_valid;
    logic        head_valid;
    logic [2:0]  head_addr;
    logic [3:0]  head_opcode;
    logic [2:0]  head_dest;
    logic [15:0] head_value;
    logic        head_predict;
    logic        re;

    int errors = 0;
    int checks = 0;

    rob_nport dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .we           (we),
        .opcode_in    (opcode_in),
        .dest_in      (dest_in),
        .value_in     (value_in),
        .ready_in     (ready_in),
        .predict_in   (predict_in),
        .alloc_addr   (alloc_addr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .sr1_tag      (sr1_tag),
        .sr2_tag      (sr2_tag),
        .sr1_value    (sr1_value),
        .sr2_value    (sr2_value),
        .sr1_valid    (sr1_valid),
        .sr2_valid    (sr2_valid),
        .head_valid   (head_valid),
        .head_addr    (head_addr),
        .head_opcode  (head_opcode),
        .head_dest    (head_dest),
        .head_value   (head_value),
        .head_predict (head_predict),
        .re           (re)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: in-flight instructions, oldest first, plus the next tag to hand out.
    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  op;
        logic [2:0]  dest;
        logic [15:0] val;
        bit          rdy;
        bit          pred;
    } ent_t;

    ent_t       q[$];
    logic [2:0] m_tail = 3'd0;

    task automatic model_lookup(input logic [2:0] tag, output bit v, output bit have,
                                output logic [15:0] val);
        v    = 1'b0;
        have = 1'b0;
        val  = '0;
        foreach (q[i]) begin
            if (q[i].tag == tag) begin
                have = 1'b1;
                val  = q[i].val;
                if (q[i].rdy) begin
                    v = 1'b1;
                end else begin
                    for (int p = 1; p >= 0; p--) begin
                        if (cdb_valid[p] && cdb_tag[p*3 +: 3] == tag) begin
                            v   = 1'b1;
                            val = cdb_value[p*16 +: 16];
                        end
                    end
                end
            end
        end
    endtask

    // Compare DUT against model, then advance the model past the coming edge.
    always @(negedge clk or negedge reset_n) begin
        bit          exp_hv;
        bit          lv;
        bit          lh;
        logic [15:0] lval;
        bit          do_alloc;
        bit          do_ret;
        ent_t        n;
        if (!reset_n) begin
            q.delete();
            m_tail = 3'd0;
        end else begin
            exp_hv = (q.size() > 0) && q[0].rdy;
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("alloc_addr", 32'(alloc_addr), 32'(m_tail));
            chk("head_valid", 32'(head_valid), 32'(exp_hv));
            chk("head_addr", 32'(head_addr), 32'((q.size() > 0) ? q[0].tag : m_tail));
            if (exp_hv) begin
                chk("head_value", 32'(head_value), 32'(q[0].val));
                chk("head_opcode", 32'(head_opcode), 32'(q[0].op));
                chk("head_dest", 32'(head_dest), 32'(q[0].dest));
                chk("head_predict", 32'(head_predict), 32'(q[0].pred));
            end
            model_lookup(sr1_tag, lv, lh, lval);
            chk("sr1_valid", 32'(sr1_valid), 32'(lv));
            if (lh) chk("sr1_value", 32'(sr1_value), 32'(lval));
            model_lookup(sr2_tag, lv, lh, lval);
            chk("sr2_valid", 32'(sr2_valid), 32'(lv));
            if (lh) chk("sr2_value", 32'(sr2_value), 32'(lval));

            if (flush) begin
                q.delete();
                m_tail = 3'd0;
            end else begin
                do_alloc = we && (q.size() < DEPTH);
                do_ret   = re && exp_hv;
                for (int p = 0; p < 2; p++) begin
                    if (cdb_valid[p]) begin
                        foreach (q[i]) begin
                            if (q[i].tag == cdb_tag[p*3 +: 3] && !q[i].rdy) begin
                                q[i].rdy = 1'b1;
                                q[i].val = cdb_value[p*16 +: 16];
                            end
                        end
                    end
                end
                if (do_ret) void'(q.pop_front());
                if (do_alloc) begin
                    n.tag  = m_tail;
                    n.op   = opcode_in;
                    n.dest = dest_in;
                    n.val  = value_in;
                    n.rdy  = ready_in;
                    n.pred = predict_in;
                    q.push_back(n);
                    m_tail = m_tail + 3'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        flush     = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        cdb_valid = 2'b00;
        cdb_tag   = '0;
        cdb_value = '0;
    endtask

    task automatic set_alloc(input logic [15:0] v, input bit rdy, input logic [3:0] op);
        we         = 1'b1;
        value_in   = v;
        ready_in   = rdy;
        opcode_in  = op;
        dest_in    = op[2:0] ^ 3'd5;
        predict_in = op[0];
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        sr1_tag    = 3'd0;
        sr2_tag    = 3'd0;
        opcode_in  = '0;
        dest_in    = '0;
        value_in   = '0;
        ready_in   = 1'b0;
        predict_in = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
        settle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_alloc_addr", 32'(alloc_addr), 32'd0);
        chk("rst_head_valid", 32'(head_valid), 32'd0);
        chk("rst_head_addr", 32'(head_addr), 32'd0);
        chk("rst_sr1_valid", 32'(sr1_valid), 32'd0);
        tick();

        // Fill to full, then an ignored ninth allocation.
        for (int i = 0; i < 8; i++) begin
            set_alloc(16'h0A00 + 16'(i), 1'b0, 4'(i));
            settle();
            chk("fill_alloc_addr", 32'(alloc_addr), 32'(i));
            tick();
        end
        idle();
        settle();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        set_alloc(16'hDEAD, 1'b1, 4'hF);
        tick();
        idle();
        settle();
        chk("over_count", 32'(count), 32'd8);
        chk("over_tail", 32'(alloc_addr), 32'd0);
        tick();

        // Out-of-order CDB results, in-order retirement.
        do_reset();
        set_alloc(16'h0000, 1'b0, 4'h3);
        tick();
        set_alloc(16'h0000, 1'b0, 4'h6);
        tick();
        idle();
        cdb_valid = 2'b11;
        cdb_tag   = {3'd0, 3'd1};
        cdb_value = {16'hBEEF, 16'h1234};
        tick();
        idle();
        re = 1'b1;
        settle();
        chk("ooo_head_valid", 32'(head_valid), 32'd1);
        chk("ooo_head_value0", 32'(head_value), 32'hBEEF);
        tick();
        settle();
        chk("ooo_head_value1", 32'(head_value), 32'h1234);
        chk("ooo_head_addr1", 32'(head_addr), 32'd1);
        tick();
        idle();
        settle();
        chk("ooo_empty", 32'(empty), 32'd1);
        tick();

        // Wraparound: fill, retire 3, allocate 3, drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(16'h0100 + 16'(i), 1'b1, 4'(i));
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            re = 1'b1;
            settle();
            chk("wrap_ret_value", 32'(head_value), 32'h0100 + 32'(k));
            tick();
        end
        idle();
        for (int j = 0; j < 3; j++) begin
            set_alloc(16'h0200 + 16'(j), 1'b1, 4'(8 + j));
            settle();
            chk("wrap_alloc_addr", 32'(alloc_addr), 32'(j));
            tick();
        end
        idle();
        for (int k = 0; k < 8; k++) begin
            re = 1'b1;
            settle();
            chk("wrap_head_addr", 32'(head_addr), 32'((3 + k) % 8));
            chk("wrap_head_value", 32'(head_value),
                (k < 5) ? 32'h0103 + 32'(k) : 32'h0200 + 32'(k - 5));
            tick();
        end
        idle();
        settle();
        chk("wrap_empty", 32'(empty), 32'd1);
        tick();

        // Same-tag collision: port 0 wins; later write to a ready entry dropped.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(16'h0300 + 16'(i), 1'b0, 4'(i));
            tick();
        end
        idle();
        sr1_tag   = 3'd2;
        cdb_valid = 2'b11;
        cdb_tag   = {3'd2, 3'd2};
        cdb_value = {16'h0022, 16'h0011};
        settle();
        chk("coll_bypass_valid", 32'(sr1_valid), 32'd1);
        chk("coll_bypass_value", 32'(sr1_value), 32'h0011);
        tick();
        idle();
        cdb_valid = 2'b01;
        cdb_tag   = {3'd0, 3'd2};
        cdb_value = {16'h0000, 16'h0033};
        settle();
        chk("coll_stored_value", 32'(sr1_value), 32'h0011);
        tick();
        idle();
        settle();
        chk("coll_drop_valid", 32'(sr1_valid), 32'd1);
        chk("coll_drop_value", 32'(sr1_value), 32'h0011);
        tick();

        // Same-cycle bypass on port 1.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(16'h0500 + 16'(i), 1'b0, 4'(i));
            tick();
        end
        idle();
        sr1_tag   = 3'd4;
        sr2_tag   = 3'd3;
        cdb_valid = 2'b10;
        cdb_tag   = {3'd4, 3'd0};
        cdb_value = {16'h00AA, 16'h0000};
        settle();
        chk("byp_sr1_valid", 32'(sr1_valid), 32'd1);
        chk("byp_sr1_value", 32'(sr1_value), 32'h00AA);
        chk("byp_sr2_valid", 32'(sr2_valid), 32'd0);
        chk("byp_sr2_value", 32'(sr2_value), 32'h0503);
        tick();

        // Flush with allocate and retire asserted, five entries live.
        idle();
        set_alloc(16'h0777, 1'b1, 4'h7);
        re    = 1'b1;
        flush = 1'b1;
        tick();
        idle();
        settle();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_alloc_addr", 32'(alloc_addr), 32'd0);
        tick();

        // Asynchronous reset pulse mid-cycle with the same live state.
        for (int i = 0; i < 5; i++) begin
            set_alloc(16'h0600 + 16'(i), 1'b1, 4'(i));
            tick();
        end
        set_alloc(16'h0888, 1'b1, 4'h8);
        re = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_alloc_addr", 32'(alloc_addr), 32'd0);
        chk("arst_head_valid", 32'(head_valid), 32'd0);
        #1;
        reset_n = 1'b1;
        re      = 1'b0;
        chk("arst_release_tag", 32'(alloc_addr), 32'd0);
        tick();
        idle();
        settle();
        chk("arst_first_count", 32'(count), 32'd1);
        chk("arst_first_value", 32'(head_value), 32'h0888);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
